parking_occupancy_tracker: RTL and testbench
============================================

Name: parking_occupancy_tracker

Overview:
Upstream stage of the parking display. Debounces the four per-slot vehicle sensors, maintains the slot occupancy map, and derives the free-slot count and lowest-index free slot consumed directly by the display block. It also runs the entry-gate controller, which opens the gate only when a slot is free.

Parameters:
DEBOUNCE_CYCLES, 10, consecutive clk_500Hz cycles a synchronised sensor must differ from its stable value before the stable value flips (20 ms at 500 Hz)
GATE_OPEN_CYCLES, 1500, cycles gate_open is held high per granted entry (3 s)
DENY_CYCLES, 250, cycles deny_alarm is held high per refused entry (0.5 s)

Ports:
clk_500Hz  input  1  system clock, 500 Hz; the only clock
reset  input  1  asynchronous, active-high reset
slot_sensor_raw  input  4  raw occupancy sensors; bit i = 1 means a vehicle is present in slot i; asynchronous to clk
entry_req  input  1  entry button, synchronous, level; edge-detected internally
capacity  output  3  number of free slots, 0..4
first_empty  output  2  lowest-index free slot; 0 when no slot is free
full  output  1  1 when capacity == 0
gate_open  output  1  entry gate drive
deny_alarm  output  1  refused-entry indicator

Behaviour:
- Clock and reset: one clock, clk_500Hz. Reset is asynchronous and active-high. All flops clear immediately when reset = 1.
- Reset values: sync flops 0, stable occupancy 4'b0000, debounce counters 0, capacity = 3'd4, first_empty = 2'd0, full = 0, gate_open = 0, deny_alarm = 0, FSM = IDLE, entry_req edge-detect flop 0.
- Synchronisation: each sensor bit passes through a 2-flop synchroniser.
- Debounce, per slot:
  - The counter increments while sync_out != stable.
  - The counter clears to 0 on any cycle where sync_out == stable.
  - When the counter would reach DEBOUNCE_CYCLES, stable flips on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Derivation (registered, one cycle after stable changes):
  - capacity = number of 0 bits in stable; the adder is 3 bits wide, so 4 is representable.
  - first_empty = index of the lowest 0 bit. Priority is slot 0 > 1 > 2 > 3. When stable == 4'b1111, first_empty = 0.
  - full = (stable == 4'b1111).
- End-to-end latency: a clean raw transition appears on capacity/first_empty exactly 2 + DEBOUNCE_CYCLES + 1 rising edges after it is first sampled.
- Entry edge detect: a request is accepted on a cycle where entry_req = 1 and it was 0 the previous cycle. A held button yields one request.
- Gate FSM states: IDLE, OPEN, DENY.
  - IDLE + request + full = 0 → OPEN. Load the timer with GATE_OPEN_CYCLES − 1; gate_open = 1 from the next edge.
  - IDLE + request + full = 1 → DENY. Load the timer with DENY_CYCLES − 1; deny_alarm = 1 from the next edge.
  - OPEN: the timer decrements each cycle; at 0 → IDLE and gate_open = 0. gate_open is high for exactly GATE_OPEN_CYCLES cycles.
  - DENY: same rule using deny_alarm and DENY_CYCLES.
  - Requests arriving in OPEN or DENY are ignored; they are not queued.
  - Occupancy changes during OPEN do not shorten the gate.
  - full and capacity are sampled in the cycle the request edge is detected.
- Timer width: sized by $clog2 of max(GATE_OPEN_CYCLES, DENY_CYCLES); no wrap occurs because the timer is loaded before it reaches 0.
- Simultaneous events: a request edge in the same cycle that full changes uses the registered full value, i.e. the old value.
- Reset mid-operation: gate_open and deny_alarm drop asynchronously, and capacity returns to 4 regardless of the sensors. The sensors re-qualify through the debouncer after reset is released.

Decomposition:
- Shared package parking_pkg holds:
  - NUM_SLOTS = 4
  - CAP_W = 3
  - IDX_W = 2
  - the gate FSM state enum (IDLE, OPEN, DENY)
  - These are also used by the display block.
- One sub-module: slot_debouncer. It is single-bit, containing the 2-flop sync, counter and stable flop, parameterised by DEBOUNCE_CYCLES, and is instantiated 4×.
- Count/priority logic and the FSM stay in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, GATE_OPEN_CYCLES = 8, DENY_CYCLES = 3.
1. Reset released, sensors 0000 → capacity = 4, first_empty = 0, full = 0; gate_open = 0 throughout.
2. Raw sensors go 0000 → 0011 → capacity = 2 and first_empty = 2 exactly 7 edges later. Then 1011 → capacity = 1, first_empty = 2. Then 1111 → capacity = 0, first_empty = 0, full = 1.
3. Glitch: bit 1 pulsed high for 3 cycles → capacity never changes. Pulsed for 6 cycles → capacity drops by 1, then recovers once the input returns low for at least 4 cycles.
4. capacity = 2 and a 1-cycle entry_req → gate_open high for exactly 8 cycles. A second entry_req during OPEN → ignored. entry_req held high for 20 cycles → only one opening.
5. full = 1 and entry_req → deny_alarm high for 3 cycles; gate_open stays 0.
6. reset asserted asynchronously mid-OPEN (between clock edges) → gate_open = 0 immediately and capacity = 4. After release with sensors 0101, capacity = 2 and first_empty = 1 after 7 edges.

Source files
------------

// File: rtl/parking_occupancy_tracker_pkg.sv
// Shared parking constants, gate FSM state type and occupancy helpers.
// Also consumed by the display block.
package parking_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int CAP_W     = 3;
   localparam int IDX_W     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      DENY = 2'd2
   } gate_state_t;

   // The 3-bit result holds 4 when every slot is free.
   function automatic logic [CAP_W-1:0] count_free(input logic [NUM_SLOTS-1:0] occ);
      logic [CAP_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         n = n + CAP_W'(~occ[i]);
      return n;
   endfunction

   // Lowest free index wins; 0 when nothing is free.
   function automatic logic [IDX_W-1:0] first_free(input logic [NUM_SLOTS-1:0] occ);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_SLOTS-1; i >= 0; i--)
         if (!occ[i]) idx = IDX_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/parking_occupancy_tracker_slot_debouncer.sv
// Single-bit sensor conditioner: two-flop synchroniser followed by a
// consecutive-cycle debounce counter guarding the stable flop.
module slot_debouncer #(
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic clk_500Hz,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any agreeing cycle resets the run, so short glitches never qualify.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
            stable_d = ~stable_q;
         else
            cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_500Hz or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Debounced slot occupancy, free-slot count / lowest free slot, and the
// entry-gate controller that only opens while a slot is free.
module parking_occupancy_tracker
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 10,
   parameter int GATE_OPEN_CYCLES = 1500,
   parameter int DENY_CYCLES      = 250
) (
   input  logic                 clk_500Hz,
   input  logic                 reset,
   input  logic [NUM_SLOTS-1:0] slot_sensor_raw,
   input  logic                 entry_req,
   output logic [CAP_W-1:0]     capacity,
   output logic [IDX_W-1:0]     first_empty,
   output logic                 full,
   output logic                 gate_open,
   output logic                 deny_alarm
);

   localparam int MAX_CYC = (GATE_OPEN_CYCLES > DENY_CYCLES) ? GATE_OPEN_CYCLES : DENY_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   logic [NUM_SLOTS-1:0] stable;

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      slot_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk_500Hz (clk_500Hz),
         .reset     (reset),
         .raw       (slot_sensor_raw[g]),
         .stable    (stable[g])
      );
   end

   logic [CAP_W-1:0] capacity_q, capacity_d;
   logic [IDX_W-1:0] first_empty_q, first_empty_d;
   logic             full_q, full_d;
   gate_state_t      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             req_prev_q, req_prev_d;
   logic             req_edge;

   always_comb begin
      capacity_d    = count_free(stable);
      first_empty_d = first_free(stable);
      full_d        = &stable;
   end

   assign req_edge = entry_req & ~req_prev_q;

   // Decisions use the registered full flag, so a same-cycle occupancy
   // change is seen one cycle late by design.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      req_prev_d = entry_req;
      case (state_q)
         IDLE: begin
            if (req_edge) begin
               if (!full_q) begin
                  state_d = OPEN;
                  timer_d = TMR_W'(GATE_OPEN_CYCLES - 1);
               end else begin
                  state_d = DENY;
                  timer_d = TMR_W'(DENY_CYCLES - 1);
               end
            end
         end
         OPEN, DENY: begin
            if (timer_q == '0)
               state_d = IDLE;
            else
               timer_d = timer_q - TMR_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_500Hz or posedge reset) begin
      if (reset) begin
         capacity_q    <= CAP_W'(NUM_SLOTS);
         first_empty_q <= '0;
         full_q        <= 1'b0;
         state_q       <= IDLE;
         timer_q       <= '0;
         req_prev_q    <= 1'b0;
      end else begin
         capacity_q    <= capacity_d;
         first_empty_q <= first_empty_d;
         full_q        <= full_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         req_prev_q    <= req_prev_d;
      end
   end

   assign capacity    = capacity_q;
   assign first_empty = first_empty_q;
   assign full        = full_q;
   assign gate_open   = (state_q == OPEN);
   assign deny_alarm  = (state_q == DENY);

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed bench for parking_occupancy_tracker with short debounce/gate timings.
module tb_parking_occupancy_tracker;

   logic       clk_500Hz = 1'b0;
   logic       reset;
   logic [3:0] slot_sensor_raw;
   logic       entry_req;
   logic [2:0] capacity;
   logic [1:0] first_empty;
   logic       full;
   logic       gate_open;
   logic       deny_alarm;

   int total = 0;
   int bad   = 0;

   parking_occupancy_tracker #(
      .DEBOUNCE_CYCLES  (4),
      .GATE_OPEN_CYCLES (8),
      .DENY_CYCLES      (3)
   ) dut (
      .clk_500Hz       (clk_500Hz),
      .reset           (reset),
      .slot_sensor_raw (slot_sensor_raw),
      .entry_req       (entry_req),
      .capacity        (capacity),
      .first_empty     (first_empty),
      .full            (full),
      .gate_open       (gate_open),
      .deny_alarm      (deny_alarm)
   );

   always #5 clk_500Hz = ~clk_500Hz;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_500Hz);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      slot_sensor_raw = 4'b0000;
      entry_req = 1'b0;
      #3;
      total++;
      if (capacity !== 3'd4 || first_empty !== 2'd0 || full !== 1'b0 ||
          gate_open !== 1'b0 || deny_alarm !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: cap=%0d fe=%0d full=%b gate=%b deny=%b want 4 0 0 0 0",
                  capacity, first_empty, full, gate_open, deny_alarm);
      end
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         total++;
         if (capacity !== 3'd4 || first_empty !== 2'd0 || full !== 1'b0 || gate_open !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset[%0d]: cap=%0d fe=%0d full=%b gate=%b want 4 0 0 0",
                     i, capacity, first_empty, full, gate_open);
         end
      end
   endtask

   task automatic test_occupancy();
      slot_sensor_raw = 4'b0011;
      tick(6);
      total++;
      if (capacity !== 3'd4) begin
         bad++;
         $display("FAIL latency_early: cap=%0d want 4 after 6 edges", capacity);
      end
      tick(1);
      total++;
      if (capacity !== 3'd2 || first_empty !== 2'd2 || full !== 1'b0) begin
         bad++;
         $display("FAIL occ_0011: cap=%0d fe=%0d full=%b want 2 2 0", capacity, first_empty, full);
      end
      slot_sensor_raw = 4'b1011;
      tick(7);
      total++;
      if (capacity !== 3'd1 || first_empty !== 2'd2 || full !== 1'b0) begin
         bad++;
         $display("FAIL occ_1011: cap=%0d fe=%0d full=%b want 1 2 0", capacity, first_empty, full);
      end
      slot_sensor_raw = 4'b1111;
      tick(7);
      total++;
      if (capacity !== 3'd0 || first_empty !== 2'd0 || full !== 1'b1) begin
         bad++;
         $display("FAIL occ_1111: cap=%0d fe=%0d full=%b want 0 0 1", capacity, first_empty, full);
      end
      slot_sensor_raw = 4'b1101;
      tick(7);
      total++;
      if (capacity !== 3'd1 || first_empty !== 2'd1 || full !== 1'b0) begin
         bad++;
         $display("FAIL occ_1101: cap=%0d fe=%0d full=%b want 1 1 0", capacity, first_empty, full);
      end
   endtask

   task automatic test_glitch();
      int changed;
      slot_sensor_raw = 4'b0000;
      tick(10);
      total++;
      if (capacity !== 3'd4) begin
         bad++;
         $display("FAIL glitch_base: cap=%0d want 4", capacity);
      end
      changed = 0;
      slot_sensor_raw = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (capacity !== 3'd4) changed++;
      end
      slot_sensor_raw = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (capacity !== 3'd4) changed++;
      end
      total++;
      if (changed !== 0) begin
         bad++;
         $display("FAIL glitch_short: capacity moved on %0d cycles, want 0", changed);
      end
      slot_sensor_raw = 4'b0010;
      tick(6);
      slot_sensor_raw = 4'b0000;
      tick(1);
      total++;
      if (capacity !== 3'd3 || first_empty !== 2'd0) begin
         bad++;
         $display("FAIL glitch_long: cap=%0d fe=%0d want 3 0", capacity, first_empty);
      end
      tick(5);
      total++;
      if (capacity !== 3'd3) begin
         bad++;
         $display("FAIL recover_early: cap=%0d want 3", capacity);
      end
      tick(1);
      total++;
      if (capacity !== 3'd4) begin
         bad++;
         $display("FAIL recover: cap=%0d want 4", capacity);
      end
   endtask

   task automatic test_gate_open();
      int highs;
      int rises;
      logic prev;
      slot_sensor_raw = 4'b0011;
      tick(10);
      total++;
      if (capacity !== 3'd2 || gate_open !== 1'b0) begin
         bad++;
         $display("FAIL gate_pre: cap=%0d gate=%b want 2 0", capacity, gate_open);
      end
      entry_req = 1'b1;
      tick(1);
      entry_req = 1'b0;
      total++;
      if (gate_open !== 1'b1 || deny_alarm !== 1'b0) begin
         bad++;
         $display("FAIL gate_start: gate=%b deny=%b want 1 0", gate_open, deny_alarm);
      end
      highs = 1;
      for (int i = 0; i < 14; i++) begin
         if (i == 3) entry_req = 1'b1;
         if (i == 4) entry_req = 1'b0;
         tick(1);
         if (gate_open === 1'b1) highs++;
      end
      total++;
      if (highs !== 8) begin
         bad++;
         $display("FAIL gate_len: gate_open high %0d cycles want 8", highs);
      end
      highs = 0;
      rises = 0;
      prev = gate_open;
      entry_req = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i == 20) entry_req = 1'b0;
         tick(1);
         if (gate_open === 1'b1) highs++;
         if (gate_open === 1'b1 && prev === 1'b0) rises++;
         prev = gate_open;
      end
      total++;
      if (highs !== 8 || rises !== 1) begin
         bad++;
         $display("FAIL gate_held: high=%0d openings=%0d want 8 1", highs, rises);
      end
   endtask

   task automatic test_deny();
      int dhigh;
      int ghigh;
      slot_sensor_raw = 4'b1111;
      tick(10);
      total++;
      if (full !== 1'b1) begin
         bad++;
         $display("FAIL deny_pre: full=%b want 1", full);
      end
      dhigh = 0;
      ghigh = 0;
      entry_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) entry_req = 1'b0;
         tick(1);
         if (deny_alarm === 1'b1) dhigh++;
         if (gate_open === 1'b1) ghigh++;
      end
      total++;
      if (dhigh !== 3 || ghigh !== 0) begin
         bad++;
         $display("FAIL deny_len: deny high %0d gate high %0d want 3 0", dhigh, ghigh);
      end
   endtask

   task automatic test_reset_mid_open();
      slot_sensor_raw = 4'b0011;
      tick(10);
      entry_req = 1'b1;
      tick(1);
      entry_req = 1'b0;
      tick(2);
      total++;
      if (gate_open !== 1'b1) begin
         bad++;
         $display("FAIL mid_open_pre: gate=%b want 1", gate_open);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (gate_open !== 1'b0 || deny_alarm !== 1'b0 || capacity !== 3'd4 || full !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: gate=%b deny=%b cap=%0d full=%b want 0 0 4 0",
                  gate_open, deny_alarm, capacity, full);
      end
      slot_sensor_raw = 4'b0101;
      tick(2);
      reset = 1'b0;
      tick(6);
      total++;
      if (capacity !== 3'd4) begin
         bad++;
         $display("FAIL post_reset_early: cap=%0d want 4", capacity);
      end
      tick(1);
      total++;
      if (capacity !== 3'd2 || first_empty !== 2'd1 || gate_open !== 1'b0) begin
         bad++;
         $display("FAIL post_reset: cap=%0d fe=%0d gate=%b want 2 1 0", capacity, first_empty, gate_open);
      end
   endtask

   initial begin
      test_reset();
      test_occupancy();
      test_glitch();
      test_gate_open();
      test_deny();
      test_reset_mid_open();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
